// File: rtl/error_metric_acc.sv
// error_metric_acc: collects error statistics for an approximate adder.
// A run is armed by start and accepts num_samples approx/exact sum pairs.
// Each pair passes a two-stage pipeline: stage 1 forms the error distance,
// stage 2 folds it into the running results. A two-cycle DRAIN lets the last
// pair land before done is raised.
module error_metric_acc #(
  parameter int N     = 16,
  parameter int CNT_W = 24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       approx_s,
  input  logic [N-1:0]       exact_s,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [N+CNT_W-1:0] sum_ed,
  output logic [N-1:0]       max_ed,
  output logic [CNT_W-1:0]   zero_exact_count,
  output logic [CNT_W-1:0]   sample_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   num_reg;
  logic               drain_cnt_reg;
  logic               in_ready_reg;
  logic               busy_reg;
  logic               done_reg;
  logic [CNT_W-1:0]   sample_count_reg;

  logic               s1_valid_reg;
  logic [N-1:0]       s1_ed_reg;
  logic               s1_mismatch_reg;
  logic               s1_zero_reg;

  logic [CNT_W-1:0]   err_count_reg;
  logic [N+CNT_W-1:0] sum_ed_reg;
  logic [N-1:0]       max_ed_reg;
  logic [CNT_W-1:0]   zero_count_reg;

  logic               accept;
  logic               clear;
  logic [CNT_W-1:0]   sample_count_next;
  logic [N-1:0]       ed_next;

  // in_ready_reg is only ever high in RUN, so it alone qualifies acceptance.
  assign accept            = in_valid && in_ready_reg;
  assign clear             = start && ((state_reg == IDLE) || (state_reg == DONE));
  assign sample_count_next = sample_count_reg + {{(CNT_W-1){1'b0}}, 1'b1};
  assign ed_next           = (approx_s >= exact_s) ? (approx_s - exact_s)
                                                   : (exact_s - approx_s);

  // Run-control FSM with registered handshake/status outputs and sample counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg        <= IDLE;
      num_reg          <= '0;
      drain_cnt_reg    <= 1'b0;
      in_ready_reg     <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      sample_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            num_reg          <= num_samples;
            sample_count_reg <= '0;
            drain_cnt_reg    <= 1'b0;
            if (num_samples == '0) begin
              // Empty run: results are already final (all zero).
              state_reg    <= DONE;
              in_ready_reg <= 1'b0;
              busy_reg     <= 1'b0;
              done_reg     <= 1'b1;
            end else begin
              state_reg    <= RUN;
              in_ready_reg <= 1'b1;
              busy_reg     <= 1'b1;
              done_reg     <= 1'b0;
            end
          end
        end
        RUN: begin
          if (accept) begin
            sample_count_reg <= sample_count_next;
            if (sample_count_next == num_reg) begin
              state_reg     <= DRAIN;
              in_ready_reg  <= 1'b0;
              drain_cnt_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // Two cycles: enough for the final pair to clear both stages.
          if (drain_cnt_reg) begin
            state_reg <= DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end else begin
            drain_cnt_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= IDLE;
          in_ready_reg <= 1'b0;
          busy_reg     <= 1'b0;
          done_reg     <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: capture error distance and classification of the accepted pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg    <= 1'b0;
      s1_ed_reg       <= '0;
      s1_mismatch_reg <= 1'b0;
      s1_zero_reg     <= 1'b0;
    end else begin
      s1_valid_reg <= accept;
      if (accept) begin
        s1_ed_reg       <= ed_next;
        s1_mismatch_reg <= (approx_s != exact_s);
        s1_zero_reg     <= (exact_s == '0);
      end
    end
  end

  // Stage 2: accumulate results; a new run clears them before any pair arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count_reg  <= '0;
      sum_ed_reg     <= '0;
      max_ed_reg     <= '0;
      zero_count_reg <= '0;
    end else if (clear) begin
      err_count_reg  <= '0;
      sum_ed_reg     <= '0;
      max_ed_reg     <= '0;
      zero_count_reg <= '0;
    end else if (s1_valid_reg) begin
      err_count_reg  <= err_count_reg + {{(CNT_W-1){1'b0}}, s1_mismatch_reg};
      sum_ed_reg     <= sum_ed_reg + {{CNT_W{1'b0}}, s1_ed_reg};
      zero_count_reg <= zero_count_reg + {{(CNT_W-1){1'b0}}, s1_zero_reg};
      if (s1_ed_reg > max_ed_reg) begin
        max_ed_reg <= s1_ed_reg;
      end
    end
  end

  assign in_ready         = in_ready_reg;
  assign busy             = busy_reg;
  assign done             = done_reg;
  assign sample_count     = sample_count_reg;
  assign err_count        = err_count_reg;
  assign sum_ed           = sum_ed_reg;
  assign max_ed           = max_ed_reg;
  assign zero_exact_count = zero_count_reg;

endmodule

// File: tb/tb_error_metric_acc.sv
// Bench for error_metric_acc: directed scenarios plus randomized runs fed from
// an ETAI approximate adder, checked every cycle against a run-level model.
module tb_error_metric_acc;
  localparam int N     = 16;
  localparam int CNT_W = 24;
  localparam int K     = 12;

  logic               clk;
  logic               rst;
  logic               start;
  logic [CNT_W-1:0]   num_samples;
  logic               in_valid;
  logic               in_ready;
  logic [N-1:0]       approx_s;
  logic [N-1:0]       exact_s;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   err_count;
  logic [N+CNT_W-1:0] sum_ed;
  logic [N-1:0]       max_ed;
  logic [CNT_W-1:0]   zero_exact_count;
  logic [CNT_W-1:0]   sample_count;

  int n_vec  = 0;
  int n_fail = 0;

  error_metric_acc #(.N(N), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .approx_s(approx_s),
    .exact_s(exact_s), .busy(busy), .done(done), .err_count(err_count),
    .sum_ed(sum_ed), .max_ed(max_ed), .zero_exact_count(zero_exact_count),
    .sample_count(sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ETAI: exact upper N-K bits (no carry in), lower K bits XOR until the first
  // position (scanning down) where both bits are 1, which and below become 1.
  function automatic logic [N-1:0] etai(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N-1:0] r;
    bit fill;
    fill = 1'b0;
    r[N-1:K] = (N-K)'(a[N-1:K] + b[N-1:K]);
    for (int i = K - 1; i >= 0; i--) begin
      if (fill) r[i] = 1'b1;
      else if (a[i] && b[i]) begin
        fill = 1'b1;
        r[i] = 1'b1;
      end else r[i] = a[i] ^ b[i];
    end
    return r;
  endfunction

  // Run-level model: which run is active, how many pairs it took, the edge at
  // which done must rise, and the final statistics of the accepted pairs.
  bit     m_active;
  longint m_target, m_acc, m_fin, edge_i;
  longint m_err, m_sum, m_max, m_zero;
  bit     cur_done, cur_ready;
  longint m_ed;

  initial edge_i = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 1'b0;
      m_target = 0;
      m_acc    = 0;
      m_fin    = -1;
      m_err    = 0;
      m_sum    = 0;
      m_max    = 0;
      m_zero   = 0;
    end else begin
      cur_done  = m_active && (m_fin >= 0) && (edge_i >= m_fin);
      cur_ready = m_active && (m_acc < m_target);
      edge_i++;
      if ((!m_active || cur_done) && start) begin
        m_active = 1'b1;
        m_target = longint'(num_samples);
        m_acc    = 0;
        m_err    = 0;
        m_sum    = 0;
        m_max    = 0;
        m_zero   = 0;
        m_fin    = (num_samples == 0) ? edge_i : -1;
      end else if (cur_ready && in_valid) begin
        m_acc++;
        m_ed = (approx_s >= exact_s) ? longint'(approx_s) - longint'(exact_s)
                                     : longint'(exact_s) - longint'(approx_s);
        if (m_ed != 0) m_err++;
        m_sum += m_ed;
        if (m_ed > m_max) m_max = m_ed;
        if (exact_s == 0) m_zero++;
        if (m_acc == m_target) m_fin = edge_i + 2;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  bit exp_done;
  always @(negedge clk) begin
    exp_done = m_active && (m_fin >= 0) && (edge_i >= m_fin);
    chk("in_ready", longint'(in_ready), longint'(m_active && (m_acc < m_target)));
    chk("done", longint'(done), longint'(exp_done));
    chk("busy", longint'(busy), longint'(m_active && !exp_done));
    chk("sample_count", longint'(sample_count), m_acc);
    if (!m_active || exp_done) begin
      chk("err_count", longint'(err_count), m_err);
      chk("sum_ed", longint'(sum_ed), m_sum);
      chk("max_ed", longint'(max_ed), m_max);
      chk("zero_exact_count", longint'(zero_exact_count), m_zero);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] e);
    in_valid = v;
    approx_s = a;
    exact_s  = e;
  endtask

  task automatic do_start(input int n);
    start       = 1'b1;
    num_samples = CNT_W'(n);
    step();
    start = 1'b0;
  endtask

  // mode 0: ETAI vs exact sum; mode 1: unconstrained random pairs.
  task automatic run_stream(input int n, input int mode, input int vprob);
    int budget;
    logic [N-1:0] a, b;
    do_start(n);
    budget = n * 8 + 20;
    while (!done && budget > 0) begin
      a = N'($urandom);
      b = N'($urandom);
      if (mode == 0) drive(($urandom_range(99) < vprob), etai(a, b), N'(a + b));
      else drive(($urandom_range(99) < vprob), a, b);
      step();
      budget--;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_vec++;
      n_fail++;
      $display("FAIL run_timeout: done=%0d after budget, required 1", done);
    end else begin
      chk("run_sample_count", longint'(sample_count), longint'(n));
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    num_samples = '0;
    drive(1'b0, '0, '0);
    step();
    step();
    rst = 1'b0;
    step();

    // Four fixed pairs back-to-back.
    do_start(4);
    drive(1'b1, 16'd5, 16'd5);          step();
    drive(1'b1, 16'h0010, 16'h0013);    step();
    drive(1'b1, 16'hFFFF, 16'h0000);    step();
    drive(1'b1, 16'h0000, 16'h0000);    step();
    drive(1'b0, '0, '0);
    step();
    chk("s1_done_early", longint'(done), 0);
    step();
    chk("s1_done", longint'(done), 1);
    chk("s1_err", longint'(err_count), 2);
    chk("s1_sum", longint'(sum_ed), 65538);
    chk("s1_max", longint'(max_ed), 65535);
    chk("s1_zero", longint'(zero_exact_count), 2);
    chk("s1_cnt", longint'(sample_count), 4);

    // Empty run.
    do_start(0);
    chk("s2_done", longint'(done), 1);
    chk("s2_ready", longint'(in_ready), 0);
    chk("s2_err", longint'(err_count), 0);
    chk("s2_sum", longint'(sum_ed), 0);
    step();

    // Gapped valid 1,0,1,0,1 then extra valid beats that must be ignored.
    do_start(3);
    for (int i = 0; i < 8; i++) begin
      drive((i >= 4) || (i % 2 == 0), N'($urandom), N'($urandom));
      step();
    end
    drive(1'b0, '0, '0);
    chk("s3_cnt", longint'(sample_count), 3);
    chk("s3_done", longint'(done), 1);

    // Reset mid-run, then a single known pair.
    do_start(5);
    drive(1'b1, 16'd100, 16'd1); step();
    drive(1'b1, 16'd9, 16'd200); step();
    drive(1'b1, 16'd1, 16'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_ready", longint'(in_ready), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_err", longint'(err_count), 0);
    chk("rst_sum", longint'(sum_ed), 0);
    chk("rst_max", longint'(max_ed), 0);
    chk("rst_zero", longint'(zero_exact_count), 0);
    chk("rst_cnt", longint'(sample_count), 0);
    step();
    rst = 1'b0;
    step();
    step();
    drive(1'b1, 16'd7, 16'd3);
    do_start(1);
    step();
    drive(1'b0, '0, '0);
    step();
    step();
    chk("s4_done", longint'(done), 1);
    chk("s4_err", longint'(err_count), 1);
    chk("s4_sum", longint'(sum_ed), 4);
    chk("s4_max", longint'(max_ed), 4);

    // start during RUN is ignored; start in DONE begins a fresh run.
    do_start(6);
    drive(1'b1, 16'd50, 16'd40); step();
    drive(1'b1, 16'd1, 16'd0);   step();
    start = 1'b1;
    num_samples = CNT_W'(2);
    drive(1'b1, 16'd3, 16'd3);   step();
    start = 1'b0;
    for (int i = 0; i < 12 && !done; i++) begin
      drive(1'b1, N'($urandom), N'($urandom));
      step();
    end
    drive(1'b0, '0, '0);
    chk("s5_cnt", longint'(sample_count), 6);
    run_stream(3, 1, 100);

    // Randomized runs: ETAI stream and unconstrained pairs.
    for (int r = 0; r < 5; r++) begin
      run_stream(4000, 0, 60 + 10 * r);
      step();
    end
    run_stream(3000, 1, 80);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
